// File: rtl/led_phase_monitor.sv
// Traffic-light LED bus checker: decodes the one-hot {yellow,green,red} bus into a
// phase, measures each phase in seconds, checks Red->Green->Yellow->Red ordering and
// per-phase durations, and raises sticky error flags.
// Optional feature: define LED_MON_TOL_EN to accept durations within +/-TOL_S seconds;
// without it an exact match is required and TOL_S has no effect.
module led_phase_monitor #(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned RED_S       = 6,
  parameter int unsigned GREEN_S     = 3,
  parameter int unsigned YELLOW_S    = 1,
  parameter int unsigned TOL_S       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  led,
  input  logic        err_clr,
  output logic [1:0]  phase,
  output logic [7:0]  phase_secs,
  output logic [7:0]  last_secs,
  output logic [15:0] loops,
  output logic        err_seq,
  output logic        err_dur,
  output logic        err_led
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRed    = 3'd1;
  localparam logic [2:0] StGreen  = 3'd2;
  localparam logic [2:0] StYellow = 3'd3;
  localparam logic [2:0] StFault  = 3'd4;

  localparam int unsigned PrescW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  // Half-second preload makes the measured duration round to the nearest second.
  localparam logic [PrescW-1:0] PrescLoad = PrescW'(TICK_CYCLES / 2);
  localparam logic [PrescW-1:0] PrescTop  = PrescW'(TICK_CYCLES - 1);

`ifdef LED_MON_TOL_EN
  localparam int unsigned Tol = TOL_S;
`else
  localparam int unsigned Tol = TOL_S * 0;
`endif

  logic [2:0]        led_q;
  logic [2:0]        state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [7:0]        secs_q, secs_d, secs_inc;
  logic [7:0]        last_q, last_d;
  logic [15:0]       loops_q, loops_d;
  logic              seq_q, seq_d, dur_q, dur_d, ledf_q, ledf_d;
  logic              checked_q, checked_d;  // current phase entered from its legal predecessor
  logic              fired_q, fired_d;      // overrun already reported in this phase
  logic [1:0]        run_q, run_d;          // consecutive legal transitions, saturating at 3
  logic              led_onehot, tick, enter, stay, legal;
  logic [1:0]        led_ph;
  logic              new_seq, new_dur, new_led;
  int unsigned       exp_s, lo_s, hi_s;

  // Decode the registered bus and per-state duration window.
  always_comb begin
    led_onehot = 1'b1;
    led_ph     = 2'd0;
    unique case (led_q)
      3'b001:  led_ph = 2'd1;
      3'b010:  led_ph = 2'd2;
      3'b100:  led_ph = 2'd3;
      default: led_onehot = 1'b0;
    endcase
    case (state_q)
      StRed:    exp_s = RED_S;
      StGreen:  exp_s = GREEN_S;
      StYellow: exp_s = YELLOW_S;
      default:  exp_s = 0;
    endcase
    lo_s     = (exp_s > Tol) ? exp_s - Tol : 0;
    hi_s     = exp_s + Tol;
    tick     = (presc_q == PrescTop);
    secs_inc = (tick && secs_q != 8'hFF) ? secs_q + 8'd1 : secs_q;
    legal    = (state_q == StRed    && led_ph == 2'd2) ||
               (state_q == StGreen  && led_ph == 2'd3) ||
               (state_q == StYellow && led_ph == 2'd1);
  end

  // Phase FSM, duration checks, loop counting and timing next-state.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    last_d    = last_q;
    loops_d   = loops_q;
    checked_d = checked_q;
    fired_d   = fired_q;
    run_d     = run_q;
    enter     = 1'b0;
    stay      = 1'b0;
    new_seq   = 1'b0;
    new_dur   = 1'b0;
    new_led   = 1'b0;

    case (state_q)
      StIdle: begin
        if (led_onehot) begin
          enter     = 1'b1;
          checked_d = 1'b0;
          run_d     = 2'd0;
        end else if (led_q != 3'b000) begin
          state_d = StFault;
          new_led = 1'b1;
        end
      end
      StRed, StGreen, StYellow: begin
        if (!led_onehot) begin
          state_d = StFault;
          new_led = 1'b1;
        end else if (led_ph != state_q[1:0]) begin
          enter = 1'b1;
          if (legal) begin
            if (checked_q) begin
              last_d = secs_q;
              if (32'(secs_q) < lo_s || 32'(secs_q) > hi_s) new_dur = 1'b1;
            end
            if (state_q == StYellow && run_q >= 2'd2) loops_d = loops_q + 16'd1;
            checked_d = 1'b1;
            run_d     = (run_q == 2'd3) ? 2'd3 : run_q + 2'd1;
          end else begin
            new_seq   = 1'b1;
            checked_d = 1'b0;
            run_d     = 2'd0;
          end
        end else begin
          stay = 1'b1;
          if (checked_q && !fired_q && 32'(secs_inc) > hi_s) begin
            new_dur = 1'b1;
            fired_d = 1'b1;
          end
        end
      end
      StFault: begin
        if (led_onehot) begin
          enter     = 1'b1;
          checked_d = 1'b0;
          run_d     = 2'd0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter) begin
      state_d = {1'b0, led_ph};
      phase_d = led_ph;
      fired_d = 1'b0;
    end

    presc_d = presc_q;
    secs_d  = secs_q;
    if (enter) begin
      presc_d = PrescLoad;
      secs_d  = 8'd0;
    end else if (stay) begin
      presc_d = tick ? '0 : presc_q + PrescW'(1);
      secs_d  = secs_inc;
    end

    // A fresh error outranks a simultaneous clear.
    seq_d  = (seq_q  & ~err_clr) | new_seq;
    dur_d  = (dur_q  & ~err_clr) | new_dur;
    ledf_d = (ledf_q & ~err_clr) | new_led;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= 3'b000;
      state_q   <= StIdle;
      phase_q   <= 2'd0;
      presc_q   <= PrescLoad;
      secs_q    <= 8'd0;
      last_q    <= 8'd0;
      loops_q   <= 16'd0;
      seq_q     <= 1'b0;
      dur_q     <= 1'b0;
      ledf_q    <= 1'b0;
      checked_q <= 1'b0;
      fired_q   <= 1'b0;
      run_q     <= 2'd0;
    end else begin
      led_q     <= led;
      state_q   <= state_d;
      phase_q   <= phase_d;
      presc_q   <= presc_d;
      secs_q    <= secs_d;
      last_q    <= last_d;
      loops_q   <= loops_d;
      seq_q     <= seq_d;
      dur_q     <= dur_d;
      ledf_q    <= ledf_d;
      checked_q <= checked_d;
      fired_q   <= fired_d;
      run_q     <= run_d;
    end
  end

  assign phase      = phase_q;
  assign phase_secs = secs_q;
  assign last_secs  = last_q;
  assign loops      = loops_q;
  assign err_seq    = seq_q;
  assign err_dur    = dur_q;
  assign err_led    = ledf_q;

endmodule

// File: tb/tb_led_phase_monitor.sv
// Randomized bench for led_phase_monitor with a timestamp-based reference model.
module tb_led_phase_monitor;

  localparam int T  = 10;
  localparam int RS = 6;
  localparam int GS = 3;
  localparam int YS = 1;
  localparam int TS = 1;
`ifdef LED_MON_TOL_EN
  localparam int Tol = TS;
`else
  localparam int Tol = 0;
`endif
  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] Y = 3'b100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  led = 3'b000;
  logic        err_clr = 1'b0;
  logic [1:0]  phase;
  logic [7:0]  phase_secs, last_secs;
  logic [15:0] loops;
  logic        err_seq, err_dur, err_led;

  led_phase_monitor #(
    .TICK_CYCLES(T), .RED_S(RS), .GREEN_S(GS), .YELLOW_S(YS), .TOL_S(TS)
  ) dut (
    .clk(clk), .rst(rst), .led(led), .err_clr(err_clr),
    .phase(phase), .phase_secs(phase_secs), .last_secs(last_secs), .loops(loops),
    .err_seq(err_seq), .err_dur(err_dur), .err_led(err_led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1..3 light phase, 4 fault; time measured by timestamps.
  bit       m_valid = 0;
  int       m_now = 0, m_entry = 0, m_mode = 0, m_phase = 0, m_frozen = 0;
  int       m_last = 0, m_loops = 0, m_run = 0;
  bit       m_chk = 0, m_fired = 0, m_eseq = 0, m_edur = 0, m_eled = 0;
  logic [2:0] m_ledq = 3'b000;

  function automatic int expect_s(int p);
    return (p == 1) ? RS : (p == 2) ? GS : YS;
  endfunction
  function automatic int lo_of(int p);
    return (expect_s(p) > Tol) ? expect_s(p) - Tol : 0;
  endfunction
  function automatic int hi_of(int p);
    return expect_s(p) + Tol;
  endfunction
  // Rounded whole seconds elapsed since phase entry, saturated.
  function automatic int secs_at(int t);
    int v;
    v = (t - m_entry + T / 2) / T;
    return (v > 255) ? 255 : v;
  endfunction
  function automatic int model_secs();
    if (m_mode == 0) return 0;
    if (m_mode == 4) return m_frozen;
    return secs_at(m_now);
  endfunction

  task automatic enter_phase(input int p, input bit c);
    m_mode  = p;
    m_phase = p;
    m_entry = m_now;
    m_chk   = c;
    m_fired = 0;
    if (!c) m_run = 0;
  endtask

  task automatic model_step();
    logic [2:0] lq;
    int tp, d, nr;
    bit oh, ns, nd, nl;
    m_now++;
    if (rst) begin
      m_valid = 1; m_ledq = 3'b000; m_mode = 0; m_phase = 0; m_frozen = 0;
      m_last = 0; m_loops = 0; m_run = 0; m_chk = 0; m_fired = 0;
      m_eseq = 0; m_edur = 0; m_eled = 0;
      return;
    end
    if (!m_valid) return;
    lq = m_ledq;
    m_ledq = led;
    ns = 0; nd = 0; nl = 0;
    oh = (lq == R) || (lq == G) || (lq == Y);
    tp = (lq == R) ? 1 : (lq == G) ? 2 : 3;
    case (m_mode)
      0: begin
        if (oh) enter_phase(tp, 0);
        else if (lq != 3'b000) begin m_mode = 4; m_frozen = 0; nl = 1; end
      end
      1, 2, 3: begin
        if (!oh) begin
          m_frozen = secs_at(m_now - 1); m_mode = 4; nl = 1;
        end else if (tp != m_mode) begin
          if (tp == (m_mode % 3) + 1) begin
            if (m_chk) begin
              d = secs_at(m_now - 1);
              m_last = d;
              if (d < lo_of(m_mode) || d > hi_of(m_mode)) nd = 1;
            end
            if (m_mode == 3 && m_run >= 2) m_loops = (m_loops + 1) % 65536;
            nr = (m_run < 3) ? m_run + 1 : 3;
            enter_phase(tp, 1);
            m_run = nr;
          end else begin
            ns = 1;
            enter_phase(tp, 0);
          end
        end else if (m_chk && !m_fired && secs_at(m_now) > hi_of(m_mode)) begin
          nd = 1; m_fired = 1;
        end
      end
      default: if (oh) enter_phase(tp, 0);
    endcase
    m_eseq = (m_eseq && !err_clr) || ns;
    m_edur = (m_edur && !err_clr) || nd;
    m_eled = (m_eled && !err_clr) || nl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, m_now);
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (m_valid) begin
      chk("phase", 32'(phase), 32'(m_phase));
      chk("phase_secs", 32'(phase_secs), 32'(model_secs()));
      chk("last_secs", 32'(last_secs), 32'(m_last));
      chk("loops", 32'(loops), 32'(m_loops));
      chk("err_seq", 32'(err_seq), 32'(m_eseq));
      chk("err_dur", 32'(err_dur), 32'(m_edur));
      chk("err_led", 32'(err_led), 32'(m_eled));
    end
  endtask

  task automatic drive(input logic [2:0] l, input int n);
    led = l;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    led = 3'b000;
    cycle();
    rst = 1'b0;
  endtask

  logic [2:0] cur, nxt;
  int dur, r, nom;

  initial begin
    do_reset();
    chk("reset phase", 32'(phase), 32'd0);
    chk("reset loops", 32'(loops), 32'd0);

    // Two full loops plus the start of a third.
    drive(R, 60);
    led = G;
    cycle();
    chk("lag1 phase", 32'(phase), 32'd1);
    cycle();
    chk("lag2 phase", 32'(phase), 32'd2);
    drive(G, 28); drive(Y, 10);
    drive(R, 60); drive(G, 30); drive(Y, 10); drive(R, 10);
    chk("loop count", 32'(loops), 32'd2);
    chk("loop last_secs", 32'(last_secs), 32'd1);
    chk("loop errs", 32'({err_seq, err_dur, err_led}), 32'd0);

    // Illegal order, clear, and clear colliding with a new error.
    do_reset();
    drive(R, 60); drive(Y, 10);
    chk("seq err", 32'(err_seq), 32'd1);
    chk("seq phase", 32'(phase), 32'd3);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("seq cleared", 32'(err_seq), 32'd0);
    led = G; cycle();
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("seq clr collide", 32'(err_seq), 32'd1);

    // Green overrun, then a 40-cycle Green.
    do_reset();
    drive(R, 60); drive(G, 50);
    chk("overrun err", 32'(err_dur), 32'd1);
    chk("overrun secs", 32'(phase_secs), 32'd5);
    do_reset();
    drive(R, 60); drive(G, 40); drive(Y, 10);
    chk("green40 err_dur", 32'(err_dur), (Tol > 0) ? 32'd0 : 32'd1);
    chk("green40 last", 32'(last_secs), 32'd4);

    // Non-one-hot mid-Red, recovery into Green.
    do_reset();
    drive(R, 60); drive(3'b011, 5);
    chk("fault err_led", 32'(err_led), 32'd1);
    chk("fault phase", 32'(phase), 32'd1);
    drive(G, 20);
    chk("recover phase", 32'(phase), 32'd2);
    chk("recover seq", 32'(err_seq), 32'd0);
    drive(Y, 10); drive(R, 3);
    chk("recover dur", 32'(err_dur), 32'd0);

    // Reset mid-Green.
    do_reset();
    drive(R, 60); drive(G, 30); drive(Y, 10); drive(R, 60); drive(G, 15);
    rst = 1'b1; led = R; cycle(); rst = 1'b0;
    chk("rst phase", 32'(phase), 32'd0);
    chk("rst last", 32'(last_secs), 32'd0);
    chk("rst loops", 32'(loops), 32'd0);
    drive(R, 60); drive(G, 30);
    chk("post-rst errs", 32'({err_seq, err_dur, err_led}), 32'd0);
    chk("post-rst last", 32'(last_secs), 32'd0);

    // Long Red: saturation and single overrun report.
    do_reset();
    drive(R, 60); drive(G, 30); drive(Y, 10); drive(R, 200);
    chk("long overrun", 32'(err_dur), 32'd1);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    drive(R, 2800);
    chk("sat secs", 32'(phase_secs), 32'd255);
    chk("sat once", 32'(err_dur), 32'd0);

    // Randomized traffic.
    do_reset();
    cur = 3'b000;
    for (int s = 0; s < 250; s++) begin
      r = int'($urandom_range(99));
      if (r < 75) begin
        nxt = (cur == R) ? G : (cur == G) ? Y : R;
        nom = (nxt == R) ? RS : (nxt == G) ? GS : YS;
        dur = nom * T + int'($urandom_range(30)) - 15;
      end else if (r < 85) begin
        nxt = 3'b001 << $urandom_range(2);
        dur = 5 + int'($urandom_range(75));
      end else begin
        nxt = 3'($urandom_range(7));
        dur = 1 + int'($urandom_range(20));
      end
      if (dur < 3) dur = 3;
      cur = nxt;
      led = nxt;
      for (int c = 0; c < dur; c++) begin
        err_clr = ($urandom_range(63) == 0);
        rst = ($urandom_range(1999) == 0);
        cycle();
      end
    end
    err_clr = 1'b0;
    rst = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
